// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared state type and frame constants for the DAC serializer
package dac_pkg;

  localparam int FRAME_BITS = 16;
  localparam int DAC_BITS   = 12;

  // Control nibbles: {A/B select, BUF, GA, SHDN}
  localparam logic [3:0] CTRL_A = 4'b0111;
  localparam logic [3:0] CTRL_B = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_A,
    S_GAP_A,
    S_SHIFT_B,
    S_GAP_B,
    S_LDAC
  } dac_state_t;

endpackage

// File: rtl/dac_serializer_sclk_phase.sv
// rtl/dac_serializer_sclk_phase.sv - sclk half-period timer with rise/fall ticks
module sclk_phase #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          last;

  // Ticks flag the cycle whose closing edge flips sclk, so the top can act on that same edge
  assign last      = !clr && (cnt == CW'(CLK_DIV - 1));
  assign rise_tick = last && !sclk;
  assign fall_tick = last && sclk;

  // Half-period counter and sclk level; held at zero/low while cleared
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (last) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dac_serializer.sv
// rtl/dac_serializer.sv - streams A/B sample pairs to a dual 12-bit SPI DAC with shared LDAC
module dac_serializer #(
  parameter int D_WIDTH = 8,
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_valid,
  output logic               sample_ready,
  input  logic [D_WIDTH-1:0] dinA,
  input  logic [D_WIDTH-1:0] dinB,
  output logic               sclk,
  output logic               mosi,
  output logic               cs_n,
  output logic               ldac_n,
  output logic               busy
);

  import dac_pkg::*;

  localparam int PAD = DAC_BITS - D_WIDTH;
  localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  dac_state_t            state, state_nx;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] frame_a;
  logic [FRAME_BITS-1:0] frame_b;
  logic [D_WIDTH-1:0]    din_b;
  logic [3:0]            bitcnt;
  logic [DW-1:0]         dly;
  logic                  dly_done;
  logic                  shift_done;
  logic                  accept;
  logic                  phase_clr;
  logic                  rise_tick;
  logic                  fall_tick;

  // Samples are left-justified in the 12-bit DAC field, zero padded below
  assign frame_a    = {CTRL_A, DAC_BITS'(dinA) << PAD};
  assign frame_b    = {CTRL_B, DAC_BITS'(din_b) << PAD};
  assign accept     = sample_valid && sample_ready;
  assign dly_done   = (dly == DW'(CLK_DIV - 1));
  // bitcnt counts sclk rises and wraps to 0 after the 16th, so the fall that follows ends the word
  assign shift_done = fall_tick && (bitcnt == 4'd0);
  assign busy       = !sample_ready;

  sclk_phase #(
    .CLK_DIV (CLK_DIV)
  ) u_phase (
    .clk       (clk),
    .rst       (rst),
    .clr       (phase_clr),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // State register plus shift register, bit counter, B-sample hold and gap/LDAC timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      shreg  <= '0;
      din_b  <= '0;
      bitcnt <= '0;
      dly    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (accept) begin
            shreg  <= frame_a;
            din_b  <= dinB;
            bitcnt <= '0;
          end
        end
        S_SHIFT_A, S_SHIFT_B: begin
          if (rise_tick) bitcnt <= bitcnt + 4'd1;
          if (fall_tick) shreg  <= {shreg[FRAME_BITS-2:0], 1'b0};
        end
        S_GAP_A: begin
          if (dly_done) begin
            shreg  <= frame_b;
            bitcnt <= '0;
          end
        end
        default: ;
      endcase
      if ((state == S_GAP_A || state == S_GAP_B || state == S_LDAC) && !dly_done)
        dly <= dly + DW'(1);
      else
        dly <= '0;
    end
  end

  // Next-state and state-decoded outputs; everything idles outside the active phases
  always_comb begin
    state_nx     = state;
    sample_ready = 1'b0;
    cs_n         = 1'b1;
    ldac_n       = 1'b1;
    mosi         = 1'b0;
    phase_clr    = 1'b1;
    case (state)
      S_IDLE: begin
        sample_ready = 1'b1;
        if (sample_valid) state_nx = S_SHIFT_A;
      end
      S_SHIFT_A: begin
        cs_n      = 1'b0;
        mosi      = shreg[FRAME_BITS-1];
        phase_clr = 1'b0;
        if (shift_done) state_nx = S_GAP_A;
      end
      S_GAP_A: begin
        if (dly_done) state_nx = S_SHIFT_B;
      end
      S_SHIFT_B: begin
        cs_n      = 1'b0;
        mosi      = shreg[FRAME_BITS-1];
        phase_clr = 1'b0;
        if (shift_done) state_nx = S_GAP_B;
      end
      S_GAP_B: begin
        if (dly_done) state_nx = S_LDAC;
      end
      S_LDAC: begin
        ldac_n = 1'b0;
        if (dly_done) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dac_serializer.sv
// tb/tb_dac_serializer.sv - scoreboard bench for dac_serializer (8-bit/div4 and 12-bit/div1 instances)
module tb_dac_serializer;

  typedef struct {
    logic [15:0] frame;
    int          nbits;
    int          viol;
    int          lowcyc;
  } cap_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sv0 = 1'b0, sv1 = 1'b0;
  logic [7:0]  a0 = '0, b0 = '0;
  logic [11:0] a1 = '0, b1 = '0;
  logic        rdy0, rdy1, sclk0, sclk1, mosi0, mosi1, cs0, cs1, ld0n, ld1n, busy0, busy1;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp0[$], exp1[$];
  cap_t        got0[$], got1[$];
  int          ldq0[$], ldq1[$];

  always #5 clk = ~clk;

  dac_serializer #(.D_WIDTH(8), .CLK_DIV(4)) dut0 (
    .clk(clk), .rst(rst), .sample_valid(sv0), .sample_ready(rdy0), .dinA(a0), .dinB(b0),
    .sclk(sclk0), .mosi(mosi0), .cs_n(cs0), .ldac_n(ld0n), .busy(busy0));

  dac_serializer #(.D_WIDTH(12), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .sample_valid(sv1), .sample_ready(rdy1), .dinA(a1), .dinB(b1),
    .sclk(sclk1), .mosi(mosi1), .cs_n(cs1), .ldac_n(ld1n), .busy(busy1));

  // Bus monitor: captures each cs_n window and each ldac_n pulse, sampled on the falling clock edge
  logic        m_s[2], m_c[2], m_m[2], m_l[2];
  logic        p_s[2], p_c[2], p_m[2];
  logic [15:0] m_f[2];
  int          m_nb[2], m_vi[2], m_lc[2], m_lw[2];
  bit          m_on[2];
  cap_t        mc;

  assign m_s[0] = sclk0; assign m_c[0] = cs0; assign m_m[0] = mosi0; assign m_l[0] = ld0n;
  assign m_s[1] = sclk1; assign m_c[1] = cs1; assign m_m[1] = mosi1; assign m_l[1] = ld1n;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        m_on[d] = 0;
        m_lw[d] = 0;
        p_c[d]  = 1'b1;
      end else begin
        if (!m_c[d]) begin
          if (p_c[d]) begin
            m_on[d] = 1; m_f[d] = '0; m_nb[d] = 0; m_vi[d] = 0; m_lc[d] = 0;
          end
          m_lc[d] = m_lc[d] + 1;
          if (m_s[d] && !p_s[d]) begin
            m_f[d]  = {m_f[d][14:0], m_m[d]};
            m_nb[d] = m_nb[d] + 1;
          end
          if (m_s[d] && p_s[d] && (m_m[d] !== p_m[d])) m_vi[d] = m_vi[d] + 1;
        end else if (!p_c[d] && m_on[d]) begin
          mc.frame = m_f[d]; mc.nbits = m_nb[d]; mc.viol = m_vi[d]; mc.lowcyc = m_lc[d];
          if (d == 0) got0.push_back(mc); else got1.push_back(mc);
          m_on[d] = 0;
        end
        if (!m_l[d]) m_lw[d] = m_lw[d] + 1;
        else if (m_lw[d] > 0) begin
          if (d == 0) ldq0.push_back(m_lw[d]); else ldq1.push_back(m_lw[d]);
          m_lw[d] = 0;
        end
        p_c[d] = m_c[d];
      end
      p_s[d] = m_s[d];
      p_m[d] = m_m[d];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    repeat (3) tick();
    n_checks++;
    obs = {cs0, ld0n, sclk0, mosi0, rdy0, busy0, cs1, ld1n, sclk1, rdy1};
    if (obs !== 10'b1100101101) begin
      n_fail++; $display("FAIL reset_held: got %b expected %b", obs, 10'b1100101101);
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      obs = {cs0, ld0n, sclk0, mosi0, rdy0, busy0, cs1, ld1n, sclk1, rdy1};
      if (obs !== 10'b1100101101) begin
        n_fail++; $display("FAIL idle_cycle%0d: got %b expected %b", i, obs, 10'b1100101101);
      end
    end
  endtask

  task automatic test_basic();
    int   cnt;
    cap_t c;
    logic [15:0] e;
    got0.delete(); ldq0.delete(); exp0.delete();
    a0 = 8'hA5; b0 = 8'h3C; sv0 = 1'b1;
    exp0.push_back({4'b0111, a0, 4'h0});
    exp0.push_back({4'b1111, b0, 4'h0});
    tick();
    sv0 = 1'b0;
    cnt = 0;
    while (rdy0 !== 1'b1 && cnt < 2000) begin
      cnt++; a0 = 8'($urandom); b0 = 8'($urandom);
      tick();
    end
    n_checks++;
    if (cnt != 268) begin n_fail++; $display("FAIL basic_ready_low: got %0d expected %0d", cnt, 268); end
    for (int i = 0; i < 100 && ldq0.size() < 1; i++) tick();
    n_checks++;
    if (got0.size() != 2) begin n_fail++; $display("FAIL basic_frame_count: got %0d expected %0d", got0.size(), 2); end
    while (got0.size() > 0 && exp0.size() > 0) begin
      c = got0.pop_front(); e = exp0.pop_front();
      n_checks++;
      if (c.frame !== e) begin n_fail++; $display("FAIL basic_frame: got %h expected %h", c.frame, e); end
      n_checks++;
      if (c.nbits != 16 || c.viol != 0 || c.lowcyc != 128) begin
        n_fail++; $display("FAIL basic_framing: got rises=%0d viol=%0d low=%0d expected 16/0/128", c.nbits, c.viol, c.lowcyc);
      end
    end
    n_checks++;
    if (ldq0.size() != 1 || ldq0[0] != 4) begin
      n_fail++; $display("FAIL basic_ldac: got %0d pulses (first %0d) expected 1 pulse of 4", ldq0.size(), (ldq0.size() > 0) ? ldq0[0] : -1);
    end
  endtask

  task automatic test_back_to_back();
    cap_t c;
    logic [15:0] e;
    got0.delete(); ldq0.delete(); exp0.delete();
    for (int k = 0; k < 3 * 269; k++) begin
      sv0 = 1'b1; a0 = 8'($urandom); b0 = 8'($urandom);
      if (k % 269 == 0) begin
        n_checks++;
        if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_high k=%0d: got %b expected 1", k, rdy0); end
        exp0.push_back({4'b0111, a0, 4'h0});
        exp0.push_back({4'b1111, b0, 4'h0});
      end else if (k % 269 == 1) begin
        n_checks++;
        if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_low k=%0d: got %b expected 0", k, rdy0); end
      end
      tick();
    end
    sv0 = 1'b0;
    for (int i = 0; i < 3000 && ldq0.size() < 3; i++) tick();
    n_checks++;
    if (got0.size() != 6) begin n_fail++; $display("FAIL b2b_frame_count: got %0d expected %0d", got0.size(), 6); end
    while (got0.size() > 0 && exp0.size() > 0) begin
      c = got0.pop_front(); e = exp0.pop_front();
      n_checks++;
      if (c.frame !== e || c.nbits != 16 || c.viol != 0) begin
        n_fail++; $display("FAIL b2b_frame: got %h rises=%0d viol=%0d expected %h/16/0", c.frame, c.nbits, c.viol, e);
      end
    end
    n_checks++;
    if (ldq0.size() != 3) begin n_fail++; $display("FAIL b2b_ldac_count: got %0d expected %0d", ldq0.size(), 3); end
  endtask

  task automatic test_reset_mid();
    cap_t c;
    logic [15:0] e;
    logic [5:0] obs;
    got0.delete(); ldq0.delete(); exp0.delete();
    a0 = 8'h5A; b0 = 8'hC3; sv0 = 1'b1;
    exp0.push_back({4'b0111, a0, 4'h0});
    exp0.push_back({4'b1111, b0, 4'h0});
    tick();
    sv0 = 1'b0;
    repeat (191) tick();
    rst = 1'b0;
    #1;
    n_checks++;
    obs = {cs0, ld0n, sclk0, mosi0, rdy0, busy0};
    if (obs !== 6'b110010) begin n_fail++; $display("FAIL midreset_outputs: got %b expected %b", obs, 6'b110010); end
    repeat (3) tick();
    rst = 1'b1;
    repeat (300) tick();
    n_checks++;
    if (ldq0.size() != 0) begin n_fail++; $display("FAIL midreset_no_ldac: got %0d pulses expected 0", ldq0.size()); end
    n_checks++;
    if (got0.size() != 1) begin n_fail++; $display("FAIL midreset_frames: got %0d expected %0d", got0.size(), 1); end
    if (got0.size() > 0) begin
      c = got0.pop_front(); e = exp0.pop_front();
      n_checks++;
      if (c.frame !== e) begin n_fail++; $display("FAIL midreset_frame_a: got %h expected %h", c.frame, e); end
    end
    got0.delete(); exp0.delete();
    a0 = 8'h81; b0 = 8'h7E; sv0 = 1'b1;
    exp0.push_back({4'b0111, a0, 4'h0});
    exp0.push_back({4'b1111, b0, 4'h0});
    tick();
    sv0 = 1'b0;
    for (int i = 0; i < 1000 && ldq0.size() < 1; i++) tick();
    n_checks++;
    if (got0.size() != 2 || ldq0.size() != 1) begin
      n_fail++; $display("FAIL postreset_counts: got %0d frames %0d pulses expected 2/1", got0.size(), ldq0.size());
    end
    while (got0.size() > 0 && exp0.size() > 0) begin
      c = got0.pop_front(); e = exp0.pop_front();
      n_checks++;
      if (c.frame !== e || c.nbits != 16) begin
        n_fail++; $display("FAIL postreset_frame: got %h rises=%0d expected %h/16", c.frame, c.nbits, e);
      end
    end
  endtask

  task automatic test_wide();
    int   cnt;
    cap_t c;
    logic [15:0] e;
    got1.delete(); ldq1.delete(); exp1.delete();
    a1 = 12'hFFF; b1 = 12'h123; sv1 = 1'b1;
    exp1.push_back({4'b0111, a1});
    exp1.push_back({4'b1111, b1});
    tick();
    sv1 = 1'b0;
    n_checks++;
    if (busy1 !== 1'b1) begin n_fail++; $display("FAIL wide_busy: got %b expected 1", busy1); end
    cnt = 0;
    while (rdy1 !== 1'b1 && cnt < 500) begin
      cnt++; a1 = 12'($urandom); b1 = 12'($urandom);
      tick();
    end
    n_checks++;
    if (cnt != 67) begin n_fail++; $display("FAIL wide_ready_low: got %0d expected %0d", cnt, 67); end
    for (int i = 0; i < 50 && ldq1.size() < 1; i++) tick();
    n_checks++;
    if (got1.size() != 2) begin n_fail++; $display("FAIL wide_frame_count: got %0d expected %0d", got1.size(), 2); end
    while (got1.size() > 0 && exp1.size() > 0) begin
      c = got1.pop_front(); e = exp1.pop_front();
      n_checks++;
      if (c.frame !== e || c.nbits != 16 || c.viol != 0 || c.lowcyc != 32) begin
        n_fail++; $display("FAIL wide_frame: got %h rises=%0d viol=%0d low=%0d expected %h/16/0/32", c.frame, c.nbits, c.viol, c.lowcyc, e);
      end
    end
    n_checks++;
    if (ldq1.size() != 1 || ldq1[0] != 1) begin
      n_fail++; $display("FAIL wide_ldac: got %0d pulses (first %0d) expected 1 pulse of 1", ldq1.size(), (ldq1.size() > 0) ? ldq1[0] : -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
